// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the buffered UART transmitter.
//   - parity_e    : latched parity mode (reserved encoding folds to PAR_NONE)
//   - tx_state_e  : transmitter frame state
//   - DEFAULT_DIV : reset baud divisor (100 MHz / 115200, bit period DIV+1)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEFAULT_DIV = 867;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Bus encoding 2'b11 is reserved and behaves as "no parity".
    function automatic parity_e decode_parity(input logic [1:0] code);
        case (code)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered pointers and occupancy count.
//   Read-first: o_dout always presents the head word; i_pop advances past it.
//   Pushes while full and pops while empty are ignored.
// Ports
//   i_clk    : clock
//   i_rst    : synchronous active-high reset (empties the FIFO)
//   i_push   : write i_din at the clock edge
//   i_pop    : discard the head word at the clock edge
//   i_din    : write data
//   o_dout   : head word
//   o_full   : DEPTH words stored
//   o_empty  : no words stored
//   o_count  : words stored (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Bus writes are queued in a FIFO and sent LSB
//   first as start / DATA_W data / optional parity / 1 or 2 stop bits. The
//   bit period is (div+1) clocks with div programmable while idle.
// Ports
//   clk          : system clock
//   rst_n        : synchronous reset, active-high (1 = reset)
//   wr_valid     : push request for wr_data
//   wr_data      : word to transmit
//   wr_ready     : FIFO can accept a word (not full)
//   cfg_we       : config write strobe (taken only when idle); clears overflow
//   cfg_div      : baud divisor
//   cfg_parity   : 00 none, 01 even, 10 odd, 11 none
//   cfg_two_stop : 1 = two stop bits
//   tx_en        : permit the start of new frames
//   tx_out       : serial line, idles high, driven from a register
//   busy         : a frame is on the line
//   fifo_count   : words queued
//   overflow     : sticky, set when a push is attempted while full
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    input  logic                        cfg_we,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_two_stop,
    input  logic                        tx_en,
    output logic                        tx_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int unsigned     BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);

    // Frame state
    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [DIV_W-1:0]  w_baud_nxt;
    logic [BCW-1:0]    r_bit_cnt;
    logic [BCW-1:0]    w_bit_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic              r_par;       // even parity of the word in flight
    logic              w_par_nxt;
    logic              r_tx;
    logic              w_tx_nxt;

    // Latched configuration
    logic [DIV_W-1:0]  r_div;
    parity_e           r_parity;
    logic              r_two_stop;
    logic              r_overflow;

    // FIFO interface
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic              w_tick;
    logic              w_par_en;

    assign w_push   = wr_valid && !w_fifo_full;
    assign w_tick   = (r_baud_cnt == r_div);
    assign w_par_en = (r_parity != PAR_NONE);

    assign wr_ready = !w_fifo_full;
    assign tx_out   = r_tx;
    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (wr_data),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    // Next-state logic. tx_out is decoded from the *next* state and registered,
    // so the line changes only on clock edges and the start bit appears one
    // clock after the pop. A frame load (from IDLE, or from the last stop tick
    // for back-to-back frames) overrides everything else computed here.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_tick ? '0 : r_baud_cnt + 1'b1;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_par_nxt   = r_par;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                if (tx_en && !w_fifo_empty) begin
                    w_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = w_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // bit_cnt counts stop bits already completed
                if (w_tick) begin
                    if (r_two_stop && (r_bit_cnt == '0)) begin
                        w_bit_nxt = BCW'(1);
                    end else if (tx_en && !w_fifo_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_pop       = 1'b1;
            w_shreg_nxt = w_fifo_dout;
            w_par_nxt   = ^w_fifo_dout;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = ST_START;
        end

        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shreg_nxt[0];
            ST_PARITY: w_tx_nxt = w_par_nxt ^ (r_parity == PAR_ODD);
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Configuration is only taken between frames so a frame never changes
    // shape part-way through.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_div      <= DIV_W'(DEFAULT_DIV);
            r_parity   <= PAR_NONE;
            r_two_stop <= 1'b0;
        end else if (cfg_we && (r_state == ST_IDLE)) begin
            r_div      <= cfg_div;
            r_parity   <= decode_parity(cfg_parity);
            r_two_stop <= cfg_two_stop;
        end
    end

    // A new overflow event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else if (cfg_we) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. Expected line waveforms are built
//   from the frame format (start, LSB-first data, parity, stops, each held
//   div+1 clocks); expected data comes from a queue of accepted pushes.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              cfg_we;
    logic [DIV_W-1:0]  cfg_div;
    logic [1:0]        cfg_parity;
    logic              cfg_two_stop;
    logic              tx_en;
    logic              tx_out;
    logic              busy;
    logic [4:0]        fifo_count;
    logic              overflow;

    int n_cmp;
    int n_err;

    // Reference model state: latched config and accepted-but-unsent words
    int          m_div;
    int          m_par;      // 0 none, 1 even, 2 odd
    int          m_two;
    logic [7:0]  sb[$];

    uart_tx_fifo #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (DEPTH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (867)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .cfg_we       (cfg_we),
        .cfg_div      (cfg_div),
        .cfg_parity   (cfg_parity),
        .cfg_two_stop (cfg_two_stop),
        .tx_en        (tx_en),
        .tx_out       (tx_out),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_div = 867;
        m_par = 0;
        m_two = 0;
        sb.delete();
    endtask

    task automatic set_cfg(input int div, input int par, input int two);
        @(posedge clk); #1;
        cfg_we       = 1'b1;
        cfg_div      = DIV_W'(div);
        cfg_parity   = 2'(par);
        cfg_two_stop = 1'(two);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_div = div;
        m_par = (par == 1 || par == 2) ? par : 0;
        m_two = two;
    endtask

    task automatic push_word(input logic [7:0] d);
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    // Checks one whole frame cycle by cycle. With immediate=1 the start bit
    // must be on the very next cycle (no idle gap allowed).
    task automatic check_frame(input logic [7:0] d, input bit immediate);
        bit   exp_bits[$];
        int   per;
        int   waitc;
        int   ones;
        bit   bad;
        bit   busy_bad;
        logic got;
        per  = m_div + 1;
        ones = $countones(d);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) exp_bits.push_back(d[i]);
        if (m_par == 1) exp_bits.push_back((ones % 2) == 1);
        if (m_par == 2) exp_bits.push_back((ones % 2) == 0);
        exp_bits.push_back(1'b1);
        if (m_two != 0) exp_bits.push_back(1'b1);

        @(negedge clk);
        waitc = 0;
        if (!immediate) begin
            while (tx_out !== 1'b0 && waitc < 3000) begin
                @(negedge clk);
                waitc++;
            end
        end
        n_cmp++;
        if (tx_out !== 1'b0) begin
            n_err++;
            $display("FAIL frame_start data=%h: tx_out=%b expected 0 (waited %0d clk)", d, tx_out, waitc);
            return;
        end
        busy_bad = 1'b0;
        for (int b = 0; b < exp_bits.size(); b++) begin
            bad = 1'b0;
            got = exp_bits[b];
            for (int c = 0; c < per; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx_out !== exp_bits[b]) begin
                    bad = 1'b1;
                    got = tx_out;
                end
                if (busy !== 1'b1) busy_bad = 1'b1;
            end
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL frame_bit%0d data=%h div=%0d: tx_out=%b expected %b", b, d, m_div, got, exp_bits[b]);
            end
        end
        n_cmp++;
        if (busy_bad) begin
            n_err++;
            $display("FAIL frame_busy data=%h: busy dropped, expected 1 for %0d clk", d, exp_bits.size() * per);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s: busy=%b tx_out=%b expected busy=0 tx_out=1", name, busy, tx_out);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 ||
            wr_ready !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: tx=%b busy=%b count=%0d ready=%b ovf=%b expected 1 0 0 1 0",
                     tx_out, busy, fifo_count, wr_ready, overflow);
        end
        // reset divisor and framing: 8N1 at 868 clk/bit
        d = 8'($urandom);
        push_word(d);
        check_frame(d, 1'b0);
        check_idle("reset_default_idle");
    endtask

    task automatic test_8n1();
        set_cfg(3, 0, 0);
        push_word(8'hA5);
        check_frame(8'hA5, 1'b0);
        check_idle("8n1_idle_after_40");
    endtask

    task automatic test_parity_two_stop();
        set_cfg(1, 2, 1);
        push_word(8'h07);
        check_frame(8'h07, 1'b0);
        check_idle("odd2stop_idle_after_24");
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        tx_en = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom);
            if (sb.size() < DEPTH) sb.push_back(d);
            push_word(d);
        end
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_full: count=%0d ovf=%b ready=%b expected 16 1 0",
                     fifo_count, overflow, wr_ready);
        end
        // divisor 0 is the fastest legal rate, one clock per bit
        set_cfg(0, $urandom_range(0, 3), $urandom_range(0, 1));
        @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b0 || fifo_count !== 5'd16) begin
            n_err++;
            $display("FAIL overflow_clear: ovf=%b count=%0d expected 0 16", overflow, fifo_count);
        end
        @(posedge clk); #1;
        tx_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_frame(sb.pop_front(), i != 0);
        end
        check_idle("overflow_drain_idle");
        n_cmp++;
        if (fifo_count !== 5'd0) begin
            n_err++;
            $display("FAIL overflow_drain_count: count=%0d expected 0", fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        tx_en = 1'b0;
        set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            sb.push_back(d);
            push_word(d);
        end
        @(posedge clk); #1;
        tx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_frame(sb.pop_front(), i != 0);
        end
        check_idle("b2b_idle");
    endtask

    task automatic test_cfg_midframe();
        logic [7:0] d;
        set_cfg(2, 1, 0);
        d = 8'($urandom);
        push_word(d);
        fork
            check_frame(d, 1'b0);
            begin
                repeat (12) @(posedge clk);
                #1;
                cfg_we       = 1'b1;
                cfg_div      = 16'd9;
                cfg_parity   = 2'b10;
                cfg_two_stop = 1'b1;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join
        check_idle("cfg_mid_idle");
        // the busy-time write must not have been taken
        d = 8'($urandom);
        push_word(d);
        check_frame(d, 1'b0);
        check_idle("cfg_ignored_idle");
        set_cfg(9, 0, 0);
        d = 8'($urandom);
        push_word(d);
        check_frame(d, 1'b0);
        check_idle("cfg_div9_idle");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 1));
            d = 8'($urandom);
            push_word(d);
            check_frame(d, 1'b0);
            check_idle("random_idle");
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int waitc;
        tx_en = 1'b0;
        set_cfg(3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            push_word(d);
        end
        @(posedge clk); #1;
        tx_en = 1'b1;
        waitc = 0;
        @(negedge clk);
        while (tx_out !== 1'b0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || fifo_count !== 5'd2) begin
            n_err++;
            $display("FAIL rstmid_pre: busy=%b count=%0d expected 1 2", busy, fifo_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) begin
            n_err++;
            $display("FAIL rstmid_post: tx=%b busy=%b count=%0d expected 1 0 0", tx_out, busy, fifo_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_release: tx=%b busy=%b ovf=%b ready=%b expected 1 0 0 1",
                     tx_out, busy, overflow, wr_ready);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b1;
        wr_valid     = 1'b0;
        wr_data      = '0;
        cfg_we       = 1'b0;
        cfg_div      = '0;
        cfg_parity   = 2'b00;
        cfg_two_stop = 1'b0;
        tx_en        = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;

        test_reset();
        test_8n1();
        test_parity_two_stop();
        test_overflow();
        test_back_to_back();
        test_cfg_midframe();
        test_random();
        test_reset_midframe();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
